// File: rtl/bus_sram_slave.sv
// -----------------------------------------------------------------------------
// bus_sram_slave
//
// Burst-capable on-chip SRAM target for the shared DMA bus. Claims begin cycles
// that fall inside its address window, streams read bursts back-to-back with
// dataValidOut / endTransactionOut, accepts write bursts with optional periodic
// busy back-pressure, and answers misaligned or overlong accesses with a
// busErrorOut strobe. All outputs are registered and drive 0 when idle so the
// block can sit on a wired-OR return bus.
//
// Ports
//   clock              system clock, rising edge
//   reset              asynchronous active-low reset
//   beginTransactionIn master begin strobe, address on addressDataIn
//   addressDataIn      address on begin cycle, write data on data beats
//   readNotWriteIn     1 = read (sampled with begin)
//   burstSizeIn        beats minus one (sampled with begin)
//   byteEnablesIn      byte lanes written on every beat (sampled with begin)
//   dataValidIn        write beat valid
//   endTransactionIn   master end of write burst
//   addressDataOut     read data, 0 when not driving
//   dataValidOut       read beat valid
//   endTransactionOut  one-cycle end strobe (reads and error responses)
//   busErrorOut        one-cycle error strobe
//   busyOut            write back-pressure
// -----------------------------------------------------------------------------
module bus_sram_slave #(
  parameter logic [31:0] BASE_ADDR       = 32'h5000_0000,
  parameter int          ADDR_WORDS_LOG2 = 10,
  parameter int          READ_WAIT       = 1,
  parameter int          BUSY_PERIOD     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic        readNotWriteIn,
  input  logic [7:0]  burstSizeIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut,
  output logic        busyOut
);

  localparam int AW    = ADDR_WORDS_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int BW    = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, RD_END, WRITE, ERR} state_e;

  state_e        state, state_next;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx, begin_idx, rd_ptr;
  logic [7:0]    beat_cnt;
  logic [3:0]    wait_cnt, be_q;
  logic [BW-1:0] grp_cnt;
  logic          wr_full;
  logic          claim, misaligned, wr_accept, wr_store, load_beat, group_done;
  logic          dvo_next, eto_next, berr_next, busy_next;

  assign claim      = beginTransactionIn &&
                      (addressDataIn[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign misaligned = (addressDataIn[1:0] != 2'b00);
  assign begin_idx  = addressDataIn[AW+1:2];

  // A beat offered while busyOut is high is held by the master, not taken.
  assign wr_accept  = (state == WRITE) && dataValidIn && !busyOut;
  // Once the burst length is exhausted further beats are taken but dropped.
  assign wr_store   = wr_accept && !wr_full;
  assign group_done = (BUSY_PERIOD != 0) && wr_store &&
                      (grp_cnt == BW'(BUSY_PERIOD - 1));

  // The RAM is read one cycle ahead of the beat it feeds: whenever the next
  // state is RD_BURST the word for that beat is fetched at this edge. On the
  // begin cycle itself the index comes straight from the bus.
  assign load_beat  = (state_next == RD_BURST);
  assign rd_ptr     = (state == IDLE) ? begin_idx : idx;

  // State and output registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      dataValidOut      <= 1'b0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      busyOut           <= 1'b0;
    end else begin
      state             <= state_next;
      dataValidOut      <= dvo_next;
      endTransactionOut <= eto_next;
      busErrorOut       <= berr_next;
      busyOut           <= busy_next;
    end
  end

  // Next-state logic.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (claim) begin
          if (misaligned)          state_next = ERR;
          else if (readNotWriteIn) state_next = (READ_WAIT == 0) ? RD_BURST : RD_WAIT;
          else                     state_next = WRITE;
        end
      end
      RD_WAIT:  if (wait_cnt == 4'd1) state_next = RD_BURST;
      RD_BURST: if (beat_cnt == 8'd0) state_next = RD_END;
      RD_END:   state_next = IDLE;
      WRITE:    if (endTransactionIn) state_next = IDLE;
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output logic: values for the registered outputs in the coming cycle.
  always_comb begin
    dvo_next  = (state_next == RD_BURST);
    eto_next  = (state_next == RD_END) || (state_next == ERR);
    berr_next = (state_next == ERR) || (wr_accept && wr_full);
    busy_next = group_done && (state_next == WRITE);
  end

  // Transaction bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      be_q     <= '0;
      grp_cnt  <= '0;
      wr_full  <= 1'b0;
    end else begin
      if (load_beat)                 idx <= rd_ptr + AW'(1);
      else if (state == IDLE && claim) idx <= begin_idx;
      else if (wr_store)             idx <= idx + AW'(1);

      if (state == IDLE && claim) begin
        beat_cnt <= burstSizeIn;
        wait_cnt <= 4'(READ_WAIT);
        be_q     <= byteEnablesIn;
      end else begin
        if ((state == RD_BURST || wr_store) && beat_cnt != 8'd0)
          beat_cnt <= beat_cnt - 8'd1;
        if (state == RD_WAIT)
          wait_cnt <= wait_cnt - 4'd1;
      end

      if (state == IDLE)
        wr_full <= 1'b0;
      else if (wr_store && beat_cnt == 8'd0)
        wr_full <= 1'b1;

      if (state == IDLE)  grp_cnt <= '0;
      else if (wr_store)  grp_cnt <= group_done ? '0 : grp_cnt + BW'(1);
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM and keeps
  // its contents across a reset.
  always_ff @(posedge clock) begin
    if (wr_store) begin
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx][8*i +: 8] <= addressDataIn[8*i +: 8];
    end
  end

  // RAM read register doubles as the data output; cleared on idle cycles so
  // the bus sees 0 when this slave is not driving.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         addressDataOut <= '0;
    else if (load_beat) addressDataOut <= mem[rd_ptr];
    else                addressDataOut <= '0;
  end

endmodule

// File: tb/tb_bus_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_sram_slave
//
// Directed bench for bus_sram_slave. Two instances share the master signals:
// dut_a (window 0x5000_0000, READ_WAIT=1, never busy) and dut_b (window
// 0x5100_0000, READ_WAIT=0, BUSY_PERIOD=2). Inputs are driven and outputs
// sampled on the falling edge; expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_bus_sram_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic        beginTransactionIn, readNotWriteIn, dataValidIn, endTransactionIn;
  logic [31:0] addressDataIn;
  logic [7:0]  burstSizeIn;
  logic [3:0]  byteEnablesIn;

  logic [31:0] a_data, b_data;
  logic        a_dv, a_eto, a_berr, a_busy;
  logic        b_dv, b_eto, b_berr, b_busy;
  logic [35:0] obs_a, obs_b;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_words [16];

  assign obs_a = {a_dv, a_eto, a_berr, a_busy, a_data};
  assign obs_b = {b_dv, b_eto, b_berr, b_busy, b_data};

  always #5 clock = ~clock;

  bus_sram_slave #(
    .BASE_ADDR(32'h5000_0000), .ADDR_WORDS_LOG2(10), .READ_WAIT(1), .BUSY_PERIOD(0)
  ) dut_a (
    .clock(clock), .reset(reset),
    .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
    .readNotWriteIn(readNotWriteIn), .burstSizeIn(burstSizeIn),
    .byteEnablesIn(byteEnablesIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .addressDataOut(a_data),
    .dataValidOut(a_dv), .endTransactionOut(a_eto),
    .busErrorOut(a_berr), .busyOut(a_busy)
  );

  bus_sram_slave #(
    .BASE_ADDR(32'h5100_0000), .ADDR_WORDS_LOG2(10), .READ_WAIT(0), .BUSY_PERIOD(2)
  ) dut_b (
    .clock(clock), .reset(reset),
    .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
    .readNotWriteIn(readNotWriteIn), .burstSizeIn(burstSizeIn),
    .byteEnablesIn(byteEnablesIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .addressDataOut(b_data),
    .dataValidOut(b_dv), .endTransactionOut(b_eto),
    .busErrorOut(b_berr), .busyOut(b_busy)
  );

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Packs an expected output vector as {dv, eto, berr, busy, data}.
  function automatic logic [35:0] bus(input logic dv, input logic eto, input logic berr,
                                      input logic busy, input logic [31:0] d);
    return {dv, eto, berr, busy, d};
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic idle_bus();
    beginTransactionIn = 1'b0;
    addressDataIn      = 32'h0;
    readNotWriteIn     = 1'b0;
    burstSizeIn        = 8'h0;
    byteEnablesIn      = 4'h0;
    dataValidIn        = 1'b0;
    endTransactionIn   = 1'b0;
  endtask

  // Presents a begin cycle; returns in the following cycle (T+1).
  task automatic start(input logic [31:0] addr, input logic rnw,
                       input logic [7:0] burst, input logic [3:0] be);
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    readNotWriteIn     = rnw;
    burstSizeIn        = burst;
    byteEnablesIn      = be;
    step();
    idle_bus();
  endtask

  // Back-to-back write of exp_words[0..n-1] to dut_a, then end strobe.
  task automatic write_a(input logic [31:0] addr, input logic [3:0] be, input int n);
    start(addr, 1'b0, 8'(n - 1), be);
    for (int k = 0; k < n; k++) begin
      dataValidIn   = 1'b1;
      addressDataIn = exp_words[k];
      step();
    end
    idle_bus();
    endTransactionIn = 1'b1;
    step();
    idle_bus();
    step();
  endtask

  // Read burst; checks every cycle from T+1 through one idle cycle after the
  // end strobe against the cycle-exact expected output vector.
  task automatic read_expect(input string tag, input bit sel_b, input logic [31:0] addr,
                             input int burst, input int r);
    logic        dv, eto;
    logic [31:0] d;
    start(addr, 1'b1, 8'(burst), 4'hF);
    for (int k = 1; k <= r + burst + 3; k++) begin
      dv  = (k >= 1 + r) && (k <= 1 + r + burst);
      eto = (k == 2 + r + burst);
      if (dv) d = exp_words[k - 1 - r];
      else    d = 32'h0;
      check($sformatf("%s_c%0d", tag, k), sel_b ? obs_b : obs_a, bus(dv, eto, 1'b0, 1'b0, d));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] busy_seen;
    int          k, cyc;

    reset = 1'b0;
    idle_bus();
    repeat (3) step();
    reset = 1'b1;
    step();
    check("reset_a", obs_a, 36'h0);
    check("reset_b", obs_b, 36'h0);

    // Burst write then read-back on dut_a (READ_WAIT=1).
    exp_words[0] = 32'h1122_3344;
    exp_words[1] = 32'h5566_7788;
    exp_words[2] = 32'h99AA_BBCC;
    exp_words[3] = 32'hDDEE_FF00;
    write_a(32'h5000_0010, 4'hF, 4);
    check("wr_quiet_b", obs_b, 36'h0);
    read_expect("rd4", 1'b0, 32'h5000_0010, 3, 1);

    // Wrap-around at the top of the window (write wraps too).
    exp_words[0] = 32'hCAFE_0001;
    exp_words[1] = 32'hCAFE_0000;
    write_a(32'h5000_0FFC, 4'hF, 2);
    read_expect("wrap_b0", 1'b0, 32'h5000_0FFC, 0, 1);
    read_expect("wrap_b1", 1'b0, 32'h5000_0FFC, 1, 1);

    // Busy insertion on dut_b: master holds each beat offered under busy.
    exp_words[0] = 32'hB000_0000;
    exp_words[1] = 32'hB000_0001;
    exp_words[2] = 32'hB000_0002;
    exp_words[3] = 32'hB000_0003;
    exp_words[4] = 32'hB000_0004;
    start(32'h5100_0100, 1'b0, 8'd4, 4'hF);
    k         = 0;
    cyc       = 0;
    busy_seen = '0;
    while (k < 5 && cyc < 12) begin
      dataValidIn   = 1'b1;
      addressDataIn = exp_words[k];
      busy_seen[cyc] = b_busy;
      if (!b_busy) k++;
      cyc++;
      step();
    end
    idle_bus();
    check("busy_pattern", 36'(busy_seen), 36'h024);
    check("busy_cycles", 36'(cyc), 36'd7);
    check("busy_quiet_a", obs_a, 36'h0);
    endTransactionIn = 1'b1;
    step();
    idle_bus();
    step();
    read_expect("rd_b", 1'b1, 32'h5100_0100, 4, 0);

    // Misaligned read and write: error + end at T+1, then idle.
    start(32'h5000_0002, 1'b1, 8'd0, 4'hF);
    check("err_rd_t1", obs_a, bus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0));
    step();
    check("err_rd_t2", obs_a, 36'h0);
    start(32'h5000_0012, 1'b0, 8'd1, 4'hF);
    check("err_wr_t1", obs_a, bus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0));
    dataValidIn   = 1'b1;
    addressDataIn = 32'hDEAD_BEEF;
    step();
    check("err_wr_t2", obs_a, 36'h0);
    step();
    idle_bus();
    endTransactionIn = 1'b1;
    step();
    idle_bus();
    check("err_wr_t4", obs_a, 36'h0);
    step();
    exp_words[0] = 32'h1122_3344;
    read_expect("err_mem", 1'b0, 32'h5000_0010, 0, 1);

    // Begin outside both windows: nobody answers.
    start(32'h6000_0000, 1'b1, 8'd3, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("miss_a_c%0d", c), obs_a, 36'h0);
      check($sformatf("miss_b_c%0d", c), obs_b, 36'h0);
      step();
    end

    // Byte enables and overlong burst.
    exp_words[0] = 32'hFFFF_FFFF;
    exp_words[1] = 32'hFFFF_FFFF;
    exp_words[2] = 32'hFFFF_FFFF;
    write_a(32'h5000_0040, 4'hF, 3);
    start(32'h5000_0040, 1'b0, 8'd1, 4'b0101);
    exp_words[0] = 32'hAABB_CCDD;
    exp_words[1] = 32'h1234_5678;
    exp_words[2] = 32'h0BAD_F00D;
    for (int b = 0; b < 3; b++) begin
      check($sformatf("be_beat%0d", b), obs_a, 36'h0);
      dataValidIn   = 1'b1;
      addressDataIn = exp_words[b];
      step();
    end
    idle_bus();
    check("overflow_berr", obs_a, bus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    endTransactionIn = 1'b1;
    step();
    idle_bus();
    check("overflow_once", obs_a, 36'h0);
    step();
    exp_words[0] = 32'hFFBB_FFDD;
    exp_words[1] = 32'hFF34_FF78;
    exp_words[2] = 32'hFFFF_FFFF;
    read_expect("be_rd", 1'b0, 32'h5000_0040, 2, 1);

    // Reset during beat 2 of an 8-beat read.
    start(32'h5000_0010, 1'b1, 8'd7, 4'hF);
    step();
    check("rst_beat1", obs_a, bus(1'b1, 1'b0, 1'b0, 1'b0, 32'h1122_3344));
    step();
    check("rst_beat2", obs_a, bus(1'b1, 1'b0, 1'b0, 1'b0, 32'h5566_7788));
    #1 reset = 1'b0;
    #1 check("rst_async", obs_a, 36'h0);
    step();
    reset = 1'b1;
    step();
    check("rst_after1", obs_a, 36'h0);
    step();
    check("rst_after2", obs_a, 36'h0);
    exp_words[0] = 32'h1122_3344;
    exp_words[1] = 32'h5566_7788;
    exp_words[2] = 32'h99AA_BBCC;
    exp_words[3] = 32'hDDEE_FF00;
    read_expect("post_rst", 1'b0, 32'h5000_0010, 3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
